// File: rtl/skeleton_keypoints_pkg.sv
// Shared skeleton types: keypoint type/record and the 3x3 neighbour ring helpers.
package skeleton_keypoints_pkg;

  localparam int unsigned KP_COORD_W = 16;

  typedef enum logic {
    KP_ENDPOINT = 1'b0,
    KP_JUNCTION = 1'b1
  } kp_type_e;

  typedef struct packed {
    logic [KP_COORD_W-1:0] hcount;
    logic [KP_COORD_W-1:0] vcount;
    kp_type_e              kp_type;
  } kp_rec_t;

  // Window bit index is row*3+col, row 0 = oldest row, col 0 = oldest column.
  // Ring order starts at the top neighbour and runs clockwise.
  localparam logic [3:0] NB_ORDER [8] = '{4'd1, 4'd2, 4'd5, 4'd8, 4'd7, 4'd6, 4'd3, 4'd0};
  localparam logic [3:0] NB_CENTRE = 4'd4;

  function automatic logic [7:0] nb_ring(input logic [8:0] win);
    logic [7:0] ring;
    for (int unsigned i = 0; i < 8; i++) ring[3'(i)] = win[NB_ORDER[i]];
    return ring;
  endfunction

  function automatic logic [3:0] nb_count(input logic [7:0] ring);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) n = n + 4'(ring[3'(i)]);
    return n;
  endfunction

  function automatic logic [3:0] nb_transitions(input logic [7:0] ring);
    logic [3:0] a;
    a = '0;
    for (int unsigned i = 0; i < 8; i++)
      if (!ring[3'(i)] && ring[3'(i + 1)]) a = a + 4'd1;
    return a;
  endfunction

endpackage

// File: rtl/skeleton_keypoints_if.sv
// Keypoint output stream: coordinate/type record with valid/ready handshake.
interface skeleton_keypoints_if #(
  parameter int unsigned HWIDTH = 9,
  parameter int unsigned VWIDTH = 8
);
  logic [HWIDTH-1:0] kp_hcount_out;
  logic [VWIDTH-1:0] kp_vcount_out;
  logic              kp_type_out;
  logic              kp_valid_out;
  logic              kp_ready_in;

  modport master (
    output kp_hcount_out, kp_vcount_out, kp_type_out, kp_valid_out,
    input  kp_ready_in
  );

  modport slave (
    input  kp_hcount_out, kp_vcount_out, kp_type_out, kp_valid_out,
    output kp_ready_in
  );
endinterface

// File: rtl/skeleton_keypoints_kp_fifo.sv
// Synchronous first-word-fall-through FIFO; a write to a full FIFO succeeds only alongside a read.
module kp_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_wr, do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_in) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/skeleton_keypoints.sv
// Streaming endpoint/junction detector over a 1-bit skeleton raster with a keypoint FIFO
// and per-frame keypoint counts.
module skeleton_keypoints
  import skeleton_keypoints_pkg::*;
#(
  parameter  int unsigned HORIZONTAL_COUNT = 320,
  parameter  int unsigned VERTICAL_COUNT   = 180,
  parameter  int unsigned FIFO_DEPTH       = 16,
  localparam int unsigned HWIDTH           = $clog2(HORIZONTAL_COUNT),
  localparam int unsigned VWIDTH           = $clog2(VERTICAL_COUNT)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [HWIDTH-1:0]    hcount_in,
  input  logic [VWIDTH-1:0]    vcount_in,
  input  logic                 skeleton_in,
  input  logic                 pixel_valid_in,
  skeleton_keypoints_if.master kp,
  output logic [15:0]          endpoint_count_out,
  output logic [15:0]          junction_count_out,
  output logic                 frame_done_out,
  output logic                 overflow_out
);
  logic synced, at_origin, take;
  assign at_origin = (hcount_in == '0) && (vcount_in == '0);
  assign take      = pixel_valid_in && (synced || at_origin);

  // Stage 0: input register plus registered row-buffer reads (rows v-1, v-2)
  logic [HORIZONTAL_COUNT-1:0] row1, row2;
  logic              p0_valid, p0_cls, p0_sof, p0_eof, p0_pix, p0_up1, p0_up2;
  logic [HWIDTH-1:0] p0_h;
  logic [VWIDTH-1:0] p0_v;

  always_ff @(posedge clk_in) begin
    if (take) begin
      row1[hcount_in] <= skeleton_in;
      row2[hcount_in] <= row1[hcount_in];
    end
    p0_pix <= skeleton_in;
    p0_up1 <= row1[hcount_in];
    p0_up2 <= row2[hcount_in];
    p0_h   <= hcount_in;
    p0_v   <= vcount_in;
  end

  // Stage 1: 3x3 window, advanced only by accepted pixels
  logic [2:0][2:0]   win;
  logic              s1_cls, s1_sof, s1_eof;
  logic [HWIDTH-1:0] s1_h;
  logic [VWIDTH-1:0] s1_v;

  always_ff @(posedge clk_in) begin
    if (p0_valid) begin
      for (int unsigned r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= p0_up2;
      win[1][2] <= p0_up1;
      win[2][2] <= p0_pix;
    end
    s1_h <= p0_h - HWIDTH'(1);
    s1_v <= p0_v - VWIDTH'(1);
  end

  // Stage 2: classification register
  logic [8:0] win_flat;
  logic [7:0] ring;
  logic [3:0] n_cnt, a_cnt;
  logic       is_ep, is_jn;
  assign win_flat = win;
  assign ring     = nb_ring(win_flat);
  assign n_cnt    = nb_count(ring);
  assign a_cnt    = nb_transitions(ring);
  assign is_ep    = win_flat[NB_CENTRE] && (n_cnt == 4'd1);
  assign is_jn    = win_flat[NB_CENTRE] && (n_cnt != 4'd1) && (a_cnt >= 4'd3);

  kp_rec_t s2_rec;
  logic    s2_kp, s2_sof, s2_eof;

  always_ff @(posedge clk_in) begin
    s2_rec.hcount  <= KP_COORD_W'(s1_h);
    s2_rec.vcount  <= KP_COORD_W'(s1_v);
    s2_rec.kp_type <= is_jn ? KP_JUNCTION : KP_ENDPOINT;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      synced   <= 1'b0;
      p0_valid <= 1'b0;
      p0_cls   <= 1'b0;
      p0_sof   <= 1'b0;
      p0_eof   <= 1'b0;
      s1_cls   <= 1'b0;
      s1_sof   <= 1'b0;
      s1_eof   <= 1'b0;
      s2_kp    <= 1'b0;
      s2_sof   <= 1'b0;
      s2_eof   <= 1'b0;
    end else begin
      if (pixel_valid_in && at_origin) synced <= 1'b1;
      p0_valid <= take;
      p0_cls   <= take && (hcount_in >= HWIDTH'(2)) && (vcount_in >= VWIDTH'(2));
      p0_sof   <= take && at_origin;
      p0_eof   <= take && (hcount_in == HWIDTH'(HORIZONTAL_COUNT - 1))
                       && (vcount_in == VWIDTH'(VERTICAL_COUNT - 1));
      s1_cls   <= p0_cls;
      s1_sof   <= p0_sof;
      s1_eof   <= p0_eof;
      s2_kp    <= s1_cls && (is_ep || is_jn);
      s2_sof   <= s1_sof;
      s2_eof   <= s1_eof;
    end
  end

  // Stage 3: FIFO push, counters, frame report
  logic [$bits(kp_rec_t)-1:0] head_bits;
  kp_rec_t head;
  logic    fifo_full, fifo_empty, pop;

  kp_fifo #(
    .WIDTH ($bits(kp_rec_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .wr_en   (s2_kp),
    .wr_data (s2_rec),
    .rd_en   (pop),
    .rd_data (head_bits),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign head             = kp_rec_t'(head_bits);
  assign pop              = kp.kp_valid_out && kp.kp_ready_in;
  assign kp.kp_valid_out  = !fifo_empty;
  assign kp.kp_hcount_out = head.hcount[HWIDTH-1:0];
  assign kp.kp_vcount_out = head.vcount[VWIDTH-1:0];
  assign kp.kp_type_out   = head.kp_type;

  // The shared record carries full-width coordinates; only the frame-sized low bits leave.
  logic unused_coord_hi;
  assign unused_coord_hi = ^{head.hcount[KP_COORD_W-1:HWIDTH], head.vcount[KP_COORD_W-1:VWIDTH]};

  // Counts are copied from the next-state values so the final pixel's keypoint is included.
  logic [15:0] ep_cnt, jn_cnt, ep_next, jn_next;
  always_comb begin
    ep_next = s2_sof ? '0 : ep_cnt;
    jn_next = s2_sof ? '0 : jn_cnt;
    if (s2_kp) begin
      if (s2_rec.kp_type == KP_JUNCTION) begin
        if (jn_next != '1) jn_next = jn_next + 16'd1;
      end else if (ep_next != '1) begin
        ep_next = ep_next + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ep_cnt             <= '0;
      jn_cnt             <= '0;
      endpoint_count_out <= '0;
      junction_count_out <= '0;
      frame_done_out     <= 1'b0;
      overflow_out       <= 1'b0;
    end else begin
      ep_cnt         <= ep_next;
      jn_cnt         <= jn_next;
      frame_done_out <= s2_eof;
      if (s2_eof) begin
        endpoint_count_out <= ep_next;
        junction_count_out <= jn_next;
      end
      if (s2_kp && fifo_full && !pop) overflow_out <= 1'b1;
    end
  end
endmodule

// File: tb/tb_skeleton_keypoints.sv
// Directed bench for skeleton_keypoints on a reduced 124x92 frame with hand-computed keypoints.
module tb_skeleton_keypoints;
  localparam int unsigned H  = 124;
  localparam int unsigned V  = 92;
  localparam int unsigned HW = $clog2(H);
  localparam int unsigned VW = $clog2(V);

  typedef struct {
    int h;
    int v;
    int t;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          skel;
  logic          pvalid;
  logic [15:0]   ep_out, jn_out;
  logic          frame_done, overflow;

  skeleton_keypoints_if #(.HWIDTH(HW), .VWIDTH(VW)) kp_bus ();

  skeleton_keypoints #(
    .HORIZONTAL_COUNT (H),
    .VERTICAL_COUNT   (V),
    .FIFO_DEPTH       (16)
  ) dut (
    .clk_in             (clk),
    .rst_in             (rst),
    .hcount_in          (hcount),
    .vcount_in          (vcount),
    .skeleton_in        (skel),
    .pixel_valid_in     (pvalid),
    .kp                 (kp_bus),
    .endpoint_count_out (ep_out),
    .junction_count_out (jn_out),
    .frame_done_out     (frame_done),
    .overflow_out       (overflow)
  );

  always #5 clk = ~clk;

  logic img [V][H];
  rec_t got_q[$];
  rec_t exp_q[$];
  rec_t mon_rec;
  int   done_cnt, last_ep, last_jn;
  int   n_checks, n_errors;

  always @(negedge clk) begin
    if (!rst && kp_bus.kp_valid_out && kp_bus.kp_ready_in) begin
      mon_rec.h = int'(kp_bus.kp_hcount_out);
      mon_rec.v = int'(kp_bus.kp_vcount_out);
      mon_rec.t = int'(kp_bus.kp_type_out);
      got_q.push_back(mon_rec);
    end
    if (!rst && frame_done) begin
      done_cnt++;
      last_ep = int'(ep_out);
      last_jn = int'(jn_out);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_img();
    for (int v = 0; v < V; v++)
      for (int h = 0; h < H; h++) img[v][h] = 1'b0;
    exp_q.delete();
  endtask

  task automatic hline(input int row, input int c0, input int c1);
    for (int c = c0; c <= c1; c++) img[row][c] = 1'b1;
  endtask

  task automatic vline(input int col, input int r0, input int r1);
    for (int r = r0; r <= r1; r++) img[r][col] = 1'b1;
  endtask

  task automatic add_exp(input int h, input int v, input int t);
    rec_t r;
    r.h = h;
    r.v = v;
    r.t = t;
    exp_q.push_back(r);
  endtask

  task automatic send_rows(input int r0, input int r1, input bit gaps, input bit rst_pulse);
    for (int v = r0; v <= r1; v++) begin
      for (int h = 0; h < H; h++) begin
        if (gaps) begin
          while ($urandom_range(1, 0) == 1) begin
            @(posedge clk); #1;
            pvalid = 1'b0;
            rst    = 1'b0;
          end
        end
        @(posedge clk); #1;
        rst    = rst_pulse && (v == r0) && (h < 4);
        hcount = HW'(h);
        vcount = VW'(v);
        skel   = img[v][h];
        pvalid = 1'b1;
      end
    end
    @(posedge clk); #1;
    pvalid = 1'b0;
    rst    = 1'b0;
  endtask

  task automatic run_frame(input bit gaps);
    got_q.delete();
    done_cnt = 0;
    send_rows(0, V - 1, gaps, 1'b0);
    repeat (30) @(posedge clk);
    #1;
  endtask

  task automatic check_records(input string name);
    check({name, " records"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s rec%0d h", name, i), got_q[i].h, exp_q[i].h);
      check($sformatf("%s rec%0d v", name, i), got_q[i].v, exp_q[i].v);
      check($sformatf("%s rec%0d type", name, i), got_q[i].t, exp_q[i].t);
    end
  endtask

  task automatic check_counts(input string name, input int ep, input int jn);
    check({name, " frame_done pulses"}, done_cnt, 1);
    check({name, " endpoint count"}, last_ep, ep);
    check({name, " junction count"}, last_jn, jn);
  endtask

  task automatic load_tee();
    clear_img();
    hline(60, 100, 120);
    vline(110, 61, 70);
    add_exp(100, 60, 0);
    add_exp(110, 60, 1);
    add_exp(120, 60, 0);
    add_exp(110, 70, 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    done_cnt = 0;
    last_ep  = 0;
    last_jn  = 0;
    rst      = 1'b1;
    pvalid   = 1'b0;
    hcount   = '0;
    vcount   = '0;
    skel     = 1'b0;
    kp_bus.kp_ready_in = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset kp_valid", kp_bus.kp_valid_out, 0);
    check("reset endpoint_count", ep_out, 0);
    check("reset junction_count", jn_out, 0);
    check("reset frame_done", frame_done, 0);
    check("reset overflow", overflow, 0);

    clear_img();
    hline(50, 100, 110);
    add_exp(100, 50, 0);
    add_exp(110, 50, 0);
    run_frame(1'b0);
    check_records("line");
    check_counts("line", 2, 0);
    check("line overflow", overflow, 0);

    load_tee();
    run_frame(1'b0);
    check_records("tee");
    check_counts("tee", 3, 1);

    clear_img();
    run_frame(1'b0);
    check_records("zero");
    check_counts("zero", 0, 0);

    // 20 isolated 2-pixel segments; only the first 16 endpoints (all on row 10) fit
    clear_img();
    for (int k = 0; k < 10; k++) begin
      hline(10, 10 + 6 * k, 11 + 6 * k);
      hline(20, 10 + 6 * k, 11 + 6 * k);
    end
    for (int i = 0; i < 16; i++) add_exp(10 + 6 * (i / 2) + (i % 2), 10, 0);
    kp_bus.kp_ready_in = 1'b0;
    run_frame(1'b0);
    check("ovf overflow", overflow, 1);
    check("ovf kp_valid", kp_bus.kp_valid_out, 1);
    check_counts("ovf", 40, 0);
    got_q.delete();
    kp_bus.kp_ready_in = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_records("ovf");
    check("ovf drained", kp_bus.kp_valid_out, 0);

    // Reset at the start of row 90, stream keeps running to the end of that frame
    clear_img();
    hline(89, 10, 20);
    hline(90, 30, 40);
    got_q.delete();
    done_cnt = 0;
    send_rows(0, 89, 1'b0, 1'b0);
    send_rows(90, V - 1, 1'b0, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    check_records("rst");
    check("rst frame_done pulses", done_cnt, 0);
    check("rst overflow", overflow, 0);
    check("rst endpoint_count", ep_out, 0);

    load_tee();
    run_frame(1'b1);
    check_records("tee_gap");
    check_counts("tee_gap", 3, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
